seq_mul_wb: RTL and testbench

Iterative unsigned W×W multiplier between the register file's read ports and its write port. Operands come from the register file read outputs when the decoder asserts Start. The 2W-bit product is returned through the register file write port (WriteEn/Waddr/DataIn) as two consecutive single-register writes, high byte first. The design has one multiplier; it is not pipelined.

---
 rtl/seq_mul_wb_pkg.sv | 23 ++
 rtl/seq_mul_wb_if.sv | 25 ++
 rtl/seq_mul_wb.sv | 105 ++++++++++
 tb/tb_seq_mul_wb.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_mul_wb_pkg.sv
// rtl/seq_mul_wb_pkg.sv - shared types and constants for the shift-add multiplier
package seq_mul_wb_pkg;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int CNT_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WR_HI = 2'd2,
    WR_LO = 2'd3
  } state_e;

  // One shift-add step; acc carries the previous carry in its top bit, which is
  // always zero after the shift, so adding the full W+1 bits is equivalent.
  function automatic logic [W:0] partial_sum(input logic [W:0]   acc,
                                             input logic [W-1:0] mcand,
                                             input logic         mbit);
    return acc + (mbit ? {1'b0, mcand} : {(W+1){1'b0}});
  endfunction

endpackage

// File: rtl/seq_mul_wb_if.sv
// rtl/seq_mul_wb_if.sv - decoder-side request and register-file write port bundle
interface seq_mul_wb_if import seq_mul_wb_pkg::*; ();

  logic         Start;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic [D-1:0] DstHi;
  logic [D-1:0] DstLo;
  logic         Busy;
  logic         Done;
  logic         WriteEn;
  logic [D-1:0] Waddr;
  logic [W-1:0] DataOut;

  modport master (
    output Start, OpA, OpB, DstHi, DstLo,
    input  Busy, Done, WriteEn, Waddr, DataOut
  );

  modport slave (
    input  Start, OpA, OpB, DstHi, DstLo,
    output Busy, Done, WriteEn, Waddr, DataOut
  );

endinterface

// File: rtl/seq_mul_wb.sv
// rtl/seq_mul_wb.sv - iterative unsigned WxW multiplier writing the 2W product
// back through the register-file write port, high half first.
module seq_mul_wb import seq_mul_wb_pkg::*; (
  input  logic          Clk,
  input  logic          Reset,
  seq_mul_wb_if.slave   mul_if
);

  state_e         state_q;
  logic [W-1:0]   mcand_q;
  logic [W-1:0]   mplier_q;
  logic [W:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [D-1:0]   dst_hi_q;
  logic [D-1:0]   dst_lo_q;

  logic           busy_q;
  logic           done_q;
  logic           we_q;
  logic [D-1:0]   waddr_q;
  logic [W-1:0]   dout_q;

  logic [W:0]     sum_d;

  always_comb begin
    sum_d = partial_sum(acc_q, mcand_q, mplier_q[0]);
  end

  // Outputs are registered alongside the state so each one reflects the state
  // being entered; nothing on the request side reaches an output combinationally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dst_hi_q <= '0;
      dst_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      dout_q   <= '0;
    end else begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (mul_if.Start) begin
            mcand_q  <= mul_if.OpA;
            mplier_q <= mul_if.OpB;
            dst_hi_q <= mul_if.DstHi;
            dst_lo_q <= mul_if.DstLo;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= MUL;
          end
        end

        MUL: begin
          {acc_q, mplier_q} <= {sum_d, mplier_q} >> 1;
          cnt_q             <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W-1)) begin
            // The high half after this final shift is sum_d[W:1].
            we_q    <= 1'b1;
            waddr_q <= dst_hi_q;
            dout_q  <= sum_d[W:1];
            state_q <= WR_HI;
          end
        end

        WR_HI: begin
          we_q    <= 1'b1;
          waddr_q <= dst_lo_q;
          dout_q  <= mplier_q;
          done_q  <= 1'b1;
          state_q <= WR_LO;
        end

        WR_LO: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mul_if.Busy    = busy_q;
  assign mul_if.Done    = done_q;
  assign mul_if.WriteEn = we_q;
  assign mul_if.Waddr   = waddr_q;
  assign mul_if.DataOut = dout_q;

endmodule

// File: tb/tb_seq_mul_wb.sv
// tb/tb_seq_mul_wb.sv - self-checking bench for seq_mul_wb
module tb_seq_mul_wb;

  logic Clk;
  logic Reset;

  seq_mul_wb_if bus ();

  seq_mul_wb dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .mul_if (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] rf [16];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (bus.WriteEn === 1'b1) rf[bus.Waddr] = bus.DataOut;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  16'(bus.Busy),    16'h0);
    check({tag, ".done"},  16'(bus.Done),    16'h0);
    check({tag, ".we"},    16'(bus.WriteEn), 16'h0);
    check({tag, ".waddr"}, 16'(bus.Waddr),   16'h0);
    check({tag, ".dout"},  16'(bus.DataOut), 16'h0);
  endtask

  // Full transaction starting in the current cycle (cycle 0). spur > 0 raises
  // a second Start in that cycle, which must be ignored.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] hi, input logic [3:0] lo,
                         input int spur, input string tag);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    bus.Start = 1'b1; bus.OpA = a; bus.OpB = b; bus.DstHi = hi; bus.DstLo = lo;
    tick();
    bus.Start = 1'b0;
    bus.OpA = 8'($urandom); bus.OpB = 8'($urandom);
    bus.DstHi = 4'($urandom); bus.DstLo = 4'($urandom);
    for (int c = 1; c <= 8; c++) begin
      check({tag, ".mul_busy"}, 16'(bus.Busy),    16'h1);
      check({tag, ".mul_we"},   16'(bus.WriteEn), 16'h0);
      bus.Start = (c == spur);
      if (c == spur) bus.OpA = 8'h03;
      tick();
      bus.Start = 1'b0;
    end
    check({tag, ".hi_we"},    16'(bus.WriteEn), 16'h1);
    check({tag, ".hi_addr"},  16'(bus.Waddr),   16'(hi));
    check({tag, ".hi_data"},  16'(bus.DataOut), 16'(prod[15:8]));
    check({tag, ".hi_done"},  16'(bus.Done),    16'h0);
    tick();
    check({tag, ".lo_we"},    16'(bus.WriteEn), 16'h1);
    check({tag, ".lo_addr"},  16'(bus.Waddr),   16'(lo));
    check({tag, ".lo_data"},  16'(bus.DataOut), 16'(prod[7:0]));
    check({tag, ".lo_done"},  16'(bus.Done),    16'h1);
    check({tag, ".lo_busy"},  16'(bus.Busy),    16'h1);
    tick();
    check_idle({tag, ".end"});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    bus.Start = 1'b0; bus.OpA = '0; bus.OpB = '0; bus.DstHi = '0; bus.DstLo = '0;
    Reset = 1'b1;
    tick(); tick(); tick();
    check_idle("reset");
    Reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("idle_we", 16'(bus.WriteEn), 16'h0);
      tick();
    end
    check_idle("idle");

    run_mul(8'h0D, 8'h0B, 4'd4, 4'd5, 0, "basic");
    check("basic_rf4", 16'(rf[4]), 16'h00);
    check("basic_rf5", 16'(rf[5]), 16'h8F);

    run_mul(8'hFF, 8'hFF, 4'd1, 4'd2, 0, "carry");
    check("carry_rf1", 16'(rf[1]), 16'hFE);
    check("carry_rf2", 16'(rf[2]), 16'h01);

    run_mul(8'h00, 8'hA5, 4'd3, 4'd6, 5, "zero");
    run_mul(8'h07, 8'h09, 4'd8, 4'd9, 0, "after_ign");

    rf[7] = 8'hAA;
    run_mul(8'h10, 8'h10, 4'd7, 4'd7, 0, "same_dst");
    check("same_dst_rf7", 16'(rf[7]), 16'h00);

    bus.Start = 1'b1; bus.OpA = 8'h12; bus.OpB = 8'h34; bus.DstHi = 4'd10; bus.DstLo = 4'd11;
    tick();
    bus.Start = 1'b0;
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    check_idle("rst_mid");
    Reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("rst_no_we", 16'(bus.WriteEn), 16'h0);
      tick();
    end
    run_mul(8'h12, 8'h34, 4'd10, 4'd11, 0, "post_rst");

    for (int n = 0; n < 20; n++) begin
      logic [7:0] a, b;
      logic [3:0] h, l;
      a = 8'($urandom); b = 8'($urandom);
      h = 4'($urandom); l = 4'($urandom);
      if (n == 0) a = 8'h80;
      if (n == 1) b = 8'h01;
      run_mul(a, b, h, l, (n % 3 == 0) ? int'($urandom_range(1, 8)) : 0, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
